// File: rtl/ads8864_ctrl.sv
// ---------------------------------------------------------------------------
// ads8864_ctrl
// Conversion sequencer for a single ADS8864 16-bit SAR ADC. It pulses CNVST,
// waits out the conversion time, then clocks the result out MSB-first with
// a locally generated SCLK. The word is presented in parallel with a
// one-cycle valid strobe. Triggers come from START (single shot, ENABLE=0)
// or from an internal period counter (free run, ENABLE=1). A trigger that
// arrives while a sequence is in flight is dropped and flags OVERRUN.
//
// Ports
//   i_sysclk      system clock, all logic on the rising edge
//   i_reset_n     asynchronous active-low reset
//   i_enable      free-run mode enable
//   i_start       single-shot trigger (ignored while i_enable=1)
//   i_clr_err     clears o_overrun (a same-cycle set wins)
//   i_adc_sdout   serial data from the ADC
//   o_adc_cnvst   conversion start to the ADC
//   o_adc_sclk    serial clock to the ADC
//   o_data        last completed sample
//   o_data_valid  one-cycle strobe, o_data updated
//   o_busy        high whenever a sequence is in progress
//   o_overrun     sticky: trigger arrived while busy
// ---------------------------------------------------------------------------
module ads8864_ctrl #(
    parameter int SCLK_HALF     = 2,
    parameter int CNV_HIGH      = 4,
    parameter int CONV_CYCLES   = 140,
    parameter int NBITS         = 16,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic             i_sysclk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_start,
    input  logic             i_clr_err,
    input  logic             i_adc_sdout,
    output logic             o_adc_cnvst,
    output logic             o_adc_sclk,
    output logic [NBITS-1:0] o_data,
    output logic             o_data_valid,
    output logic             o_busy,
    output logic             o_overrun
);

    // One counter is shared by the CNV and WAIT phases.
    localparam int CNT_MAX = (CNV_HIGH > CONV_CYCLES) ? CNV_HIGH : CONV_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int HALF_W  = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int BIT_W   = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int PER_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNV,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [HALF_W-1:0] r_half;
    logic [BIT_W-1:0] r_bit;
    logic [PER_W-1:0] r_per_cnt;
    logic [NBITS-1:0] r_shreg;
    logic [NBITS-1:0] r_data;
    logic             r_cnvst;
    logic             r_sclk;
    logic             r_dv;
    logic             r_busy;
    logic             r_overrun;

    logic             w_tick;
    logic             w_trig;
    logic [NBITS-1:0] w_shin;

    // Period counter idles at 0 while disabled, so the first tick lands on
    // the first enabled cycle and then every SAMPLE_PERIOD cycles.
    assign w_tick = i_enable && (r_per_cnt == '0);
    assign w_trig = i_enable ? w_tick : i_start;
    assign w_shin = {r_shreg[NBITS-2:0], i_adc_sdout};

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_per_cnt <= '0;
        end else if (!i_enable) begin
            r_per_cnt <= '0;
        end else if (r_per_cnt == PER_W'(SAMPLE_PERIOD - 1)) begin
            r_per_cnt <= '0;
        end else begin
            r_per_cnt <= r_per_cnt + PER_W'(1);
        end
    end

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_half    <= '0;
            r_bit     <= '0;
            r_shreg   <= '0;
            r_data    <= '0;
            r_cnvst   <= 1'b0;
            r_sclk    <= 1'b0;
            r_dv      <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_dv <= 1'b0;

            // A dropped trigger has priority over the clear.
            if (w_trig && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (i_clr_err) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_state <= S_CNV;
                        r_cnvst <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end

                S_CNV: begin
                    if (r_cnt == CNT_W'(CNV_HIGH - 1)) begin
                        r_cnvst <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_WAIT: begin
                    if (r_cnt == CNT_W'(CONV_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_half  <= '0;
                        r_bit   <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_SHIFT: begin
                    if (r_half == HALF_W'(SCLK_HALF - 1)) begin
                        r_half <= '0;
                        r_sclk <= ~r_sclk;
                        // SCLK currently high: this edge drives it low and
                        // captures the bit the ADC has been presenting.
                        if (r_sclk) begin
                            r_shreg <= w_shin;
                            if (r_bit == BIT_W'(NBITS - 1)) begin
                                // Result and strobe are registered on the
                                // last falling edge so they appear in DONE.
                                r_data  <= w_shin;
                                r_dv    <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_bit <= r_bit + BIT_W'(1);
                            end
                        end
                    end else begin
                        r_half <= r_half + HALF_W'(1);
                    end
                end

                S_DONE: begin
                    r_bit   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnvst <= 1'b0;
                    r_sclk  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_adc_cnvst  = r_cnvst;
    assign o_adc_sclk   = r_sclk;
    assign o_data       = r_data;
    assign o_data_valid = r_dv;
    assign o_busy       = r_busy;
    assign o_overrun    = r_overrun;

endmodule
